// File: rtl/seat_sprite_scheduler_if.sv
// Seat occupancy update handshake and shared sprite ROM port.
interface seat_sprite_scheduler_if;
  logic        upd_valid;
  logic [3:0]  upd_seat;
  logic [1:0]  upd_sprite;
  logic        upd_ready;
  logic [1:0]  rom_sprite;
  logic [4:0]  rom_row;
  logic [4:0]  rom_col;
  logic [11:0] rom_data;

  modport master (
    output upd_valid, upd_seat, upd_sprite, rom_data,
    input  upd_ready, rom_sprite, rom_row, rom_col
  );

  modport slave (
    input  upd_valid, upd_seat, upd_sprite, rom_data,
    output upd_ready, rom_sprite, rom_row, rom_col
  );
endinterface

// File: rtl/seat_sprite_scheduler.sv
// Shared sprite ROM scheduler for the seating grid: per-pixel seat hit
// decode, ROM addressing, transparent compositing, and tear-free occupancy
// updates through a shadow table committed at the frame boundary.
module seat_sprite_scheduler #(
  parameter int BASE_X       = 300,
  parameter int BASE_Y       = 300,
  parameter int SEAT_W       = 45,
  parameter int SEAT_H       = 45,
  parameter int SEAT_SPACING = 15,
  parameter int COLS         = 4,
  parameter int ROWS         = 2,
  parameter int SPR_W        = 32,
  parameter int SPR_H        = 32,
  parameter int V_COMMIT     = 480,
  parameter logic [11:0] TRANSPARENT = 12'hFFF
) (
  input  logic        ClkPort,
  input  logic        rst,
  input  logic        bright,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic [11:0] background,
  seat_sprite_scheduler_if.slave bus,
  output logic [15:0] occupancy,
  output logic        frame_tick,
  output logic [11:0] rgb
);

  localparam int NUM_SEATS = COLS * ROWS;
  localparam int PITCH_X   = SEAT_W + SEAT_SPACING;
  localparam int PITCH_Y   = SEAT_H + SEAT_SPACING;
  localparam int OFF_X     = (SEAT_W - SPR_W) / 2;
  localparam int OFF_Y     = (SEAT_H - SPR_H) / 2;

  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

  state_t state, state_next;

  logic [2*NUM_SEATS-1:0] shadow;
  logic [2*NUM_SEATS-1:0] committed;

  logic        boundary;
  logic        accept;
  logic        in_range;
  logic        hit;
  logic        hit_d;
  logic        bright_d;
  logic [11:0] background_d;

  int h, v, ox, oy;

  assign boundary  = (vCount == 10'(V_COMMIT)) && (hCount == '0);
  assign accept    = bus.upd_valid && bus.upd_ready;
  assign in_range  = int'(bus.upd_seat) < NUM_SEATS;
  assign occupancy = 16'(committed);

  // Hit decode and ROM addressing; lowest-index hitting seat wins.
  always_comb begin
    hit            = 1'b0;
    bus.rom_sprite = '0;
    bus.rom_row    = '0;
    bus.rom_col    = '0;
    h  = int'(hCount);
    v  = int'(vCount);
    ox = 0;
    oy = 0;
    for (int unsigned i = 0; i < NUM_SEATS; i++) begin
      ox = BASE_X + int'(i % COLS) * PITCH_X + OFF_X;
      oy = BASE_Y + int'(i / COLS) * PITCH_Y + OFF_Y;
      if (!hit && committed[2*i +: 2] != 2'b00 &&
          h >= ox && h < ox + SPR_W && v >= oy && v < oy + SPR_H) begin
        hit            = 1'b1;
        bus.rom_sprite = committed[2*i +: 2];
        bus.rom_row    = 5'(v - oy);
        bus.rom_col    = 5'(h - ox);
      end
    end
  end

  // Update FSM state register.
  always_ff @(posedge ClkPort or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Update FSM next state and write handshake.
  always_comb begin
    state_next    = state;
    bus.upd_ready = !rst && (state != COMMIT);
    unique case (state)
      IDLE: begin
        // An in-range write landing on the boundary itself commits at once,
        // so a boundary-cycle write is always part of that frame's commit.
        if (accept && in_range) state_next = boundary ? COMMIT : PENDING;
      end
      PENDING: begin
        if (boundary) state_next = COMMIT;
      end
      COMMIT: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shadow table: accepted in-range writes; out-of-range writes are dropped.
  always_ff @(posedge ClkPort or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (accept && in_range) begin
      for (int unsigned i = 0; i < NUM_SEATS; i++) begin
        if (int'(bus.upd_seat) == int'(i)) shadow[2*i +: 2] <= bus.upd_sprite;
      end
    end
  end

  // Committed table copies the shadow at the end of the COMMIT cycle.
  always_ff @(posedge ClkPort or posedge rst) begin
    if (rst)                  committed <= '0;
    else if (state == COMMIT) committed <= shadow;
  end

  // Pixel pipeline: align hit/bright/background with ROM data, then composite.
  always_ff @(posedge ClkPort or posedge rst) begin
    if (rst) begin
      hit_d        <= 1'b0;
      bright_d     <= 1'b0;
      background_d <= '0;
      rgb          <= '0;
      frame_tick   <= 1'b0;
    end else begin
      hit_d        <= hit;
      bright_d     <= bright;
      background_d <= background;
      frame_tick   <= boundary;
      if (!bright_d)                                rgb <= '0;
      else if (hit_d && bus.rom_data != TRANSPARENT) rgb <= bus.rom_data;
      else                                          rgb <= background_d;
    end
  end

endmodule

// File: tb/tb_seat_sprite_scheduler.sv
// Directed bench for seat_sprite_scheduler: pixel table plus commit sequences.
module tb_seat_sprite_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        bright;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic [11:0] background;
  logic [15:0] occupancy;
  logic        frame_tick;
  logic [11:0] rgb;

  int vectors = 0;
  int miscompares = 0;

  seat_sprite_scheduler_if bus();

  seat_sprite_scheduler dut (
    .ClkPort    (clk),
    .rst        (rst),
    .bright     (bright),
    .hCount     (hCount),
    .vCount     (vCount),
    .background (background),
    .bus        (bus.slave),
    .occupancy  (occupancy),
    .frame_tick (frame_tick),
    .rgb        (rgb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        br;
    logic [11:0] bg;
    logic [11:0] rd;
    logic [1:0]  e_spr;
    logic [4:0]  e_row;
    logic [4:0]  e_col;
    logic [11:0] e_rgb;
  } pix_vec_t;

  pix_vec_t tbl[8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the boundary cycle (vCount=480, hCount=0).
  task automatic to_boundary();
    hCount = 10'd799; vCount = 10'd479;
    tick();
    hCount = 10'd0; vCount = 10'd480;
    #1;
  endtask

  initial begin
    tbl[0] = '{10'd366, 10'd306, 1'b1, 12'h123, 12'hF00, 2'd2, 5'd0,  5'd0,  12'hF00};
    tbl[1] = '{10'd366, 10'd306, 1'b1, 12'h123, 12'hFFF, 2'd2, 5'd0,  5'd0,  12'h123};
    tbl[2] = '{10'd398, 10'd306, 1'b1, 12'h456, 12'hF00, 2'd0, 5'd0,  5'd0,  12'h456};
    tbl[3] = '{10'd397, 10'd337, 1'b1, 12'h123, 12'h0AB, 2'd2, 5'd31, 5'd31, 12'h0AB};
    tbl[4] = '{10'd380, 10'd320, 1'b0, 12'h123, 12'hF00, 2'd2, 5'd14, 5'd14, 12'h000};
    tbl[5] = '{10'd365, 10'd306, 1'b1, 12'h789, 12'hF00, 2'd0, 5'd0,  5'd0,  12'h789};
    tbl[6] = '{10'd366, 10'd338, 1'b1, 12'hABC, 12'hF00, 2'd0, 5'd0,  5'd0,  12'hABC};
    tbl[7] = '{10'd306, 10'd306, 1'b1, 12'h222, 12'hF00, 2'd0, 5'd0,  5'd0,  12'h222};

    rst = 1'b1; bright = 1'b0; hCount = '0; vCount = '0; background = '0;
    bus.upd_valid = 1'b0; bus.upd_seat = '0; bus.upd_sprite = '0; bus.rom_data = '0;
    #12;
    check("rst_upd_ready", 16'(bus.upd_ready), 16'h0);
    check("rst_occupancy", occupancy, 16'h0);
    check("rst_rgb", 16'(rgb), 16'h0);
    check("rst_frame_tick", 16'(frame_tick), 16'h0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_upd_ready", 16'(bus.upd_ready), 16'h1);

    // Empty grid shows background.
    bright = 1'b1; background = 12'h123; hCount = 10'd366; vCount = 10'd306;
    bus.rom_data = 12'hF00;
    tick(); tick();
    check("empty_rgb", 16'(rgb), 16'h123);
    check("empty_rom_sprite", 16'(bus.rom_sprite), 16'h0);

    // Seat 1 <- 2, committed only at the frame boundary.
    hCount = 10'd5; vCount = 10'd100;
    bus.upd_valid = 1'b1; bus.upd_seat = 4'd1; bus.upd_sprite = 2'd2;
    tick();
    bus.upd_valid = 1'b0;
    check("pending_occupancy", occupancy, 16'h0);
    to_boundary();
    check("b_frame_tick", 16'(frame_tick), 16'h0);
    tick();
    hCount = 10'd1;
    check("b1_frame_tick", 16'(frame_tick), 16'h1);
    check("b1_occupancy", occupancy, 16'h0);
    check("b1_upd_ready", 16'(bus.upd_ready), 16'h0);
    tick();
    check("b2_occupancy", occupancy, 16'h0008);
    check("b2_frame_tick", 16'(frame_tick), 16'h0);

    // Pixel vectors against the committed seat 1 sprite.
    for (int k = 0; k < 8; k++) begin
      hCount = tbl[k].h; vCount = tbl[k].v; bright = tbl[k].br; background = tbl[k].bg;
      bus.rom_data = 12'h000;
      #1;
      check($sformatf("v%0d_rom_sprite", k), 16'(bus.rom_sprite), 16'(tbl[k].e_spr));
      check($sformatf("v%0d_rom_row", k), 16'(bus.rom_row), 16'(tbl[k].e_row));
      check($sformatf("v%0d_rom_col", k), 16'(bus.rom_col), 16'(tbl[k].e_col));
      tick();
      bus.rom_data = tbl[k].rd;
      hCount = 10'd0; vCount = 10'd0; bright = 1'b1; background = 12'h000;
      tick();
      check($sformatf("v%0d_rgb", k), 16'(rgb), 16'(tbl[k].e_rgb));
    end
    bright = 1'b1;

    // Boundary-cycle write joins the commit; COMMIT-cycle write stalls.
    hCount = 10'd5; vCount = 10'd200;
    bus.upd_valid = 1'b1; bus.upd_seat = 4'd2; bus.upd_sprite = 2'd1;
    tick();
    bus.upd_valid = 1'b0;
    to_boundary();
    bus.upd_valid = 1'b1; bus.upd_seat = 4'd3; bus.upd_sprite = 2'd3;
    #1;
    check("bnd_upd_ready", 16'(bus.upd_ready), 16'h1);
    tick();
    hCount = 10'd1;
    bus.upd_seat = 4'd0; bus.upd_sprite = 2'd1;
    check("commit_upd_ready", 16'(bus.upd_ready), 16'h0);
    tick();
    check("commit_occupancy", occupancy, 16'h00D8);
    check("after_commit_upd_ready", 16'(bus.upd_ready), 16'h1);
    tick();
    bus.upd_valid = 1'b0;
    check("stalled_not_committed", occupancy, 16'h00D8);
    to_boundary();
    tick(); hCount = 10'd1;
    tick();
    check("stalled_committed_next_frame", occupancy, 16'h00D9);

    // Out-of-range seat is consumed but leaves the FSM idle.
    hCount = 10'd5; vCount = 10'd50;
    bus.upd_valid = 1'b1; bus.upd_seat = 4'd9; bus.upd_sprite = 2'd3;
    #1;
    check("oor_upd_ready", 16'(bus.upd_ready), 16'h1);
    tick();
    bus.upd_valid = 1'b0;
    to_boundary();
    tick(); hCount = 10'd1;
    check("oor_no_commit_ready", 16'(bus.upd_ready), 16'h1);
    check("oor_frame_tick", 16'(frame_tick), 16'h1);
    tick();
    check("oor_occupancy", occupancy, 16'h00D9);

    // Reset during PENDING discards the shadow write.
    hCount = 10'd5; vCount = 10'd60;
    bus.upd_valid = 1'b1; bus.upd_seat = 4'd4; bus.upd_sprite = 2'd3;
    tick();
    bus.upd_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_occupancy", occupancy, 16'h0);
    check("mid_rst_upd_ready", 16'(bus.upd_ready), 16'h0);
    check("mid_rst_rgb", 16'(rgb), 16'h0);
    tick();
    rst = 1'b0;
    to_boundary();
    tick(); hCount = 10'd1;
    check("rst_no_commit_ready", 16'(bus.upd_ready), 16'h1);
    tick();
    check("rst_no_commit_occupancy", occupancy, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seat_sprite_scheduler.md
# seat_sprite_scheduler

Shares one multi-character sprite ROM among all seats of the seating grid. It decides per pixel which seat, if any, owns the beam and issues that occupant's ROM address. It composites the returned texel over the background with white as transparent. Seat-occupancy updates from game logic are buffered in a shadow table and committed only at a frame boundary, so the image never tears. It sits between the game FSM and the VGA output mux, in place of per-seat sprite controllers.

## Interface
- BASE_X, 300: x of seat 0 top-left.
- BASE_Y, 300: y of seat 0 top-left.
- SEAT_W / SEAT_H, 45 / 45: seat cell size.
- SEAT_SPACING, 15: gap between cells, in both axes.
- COLS, 4: seats per row.
- ROWS, 2: seat rows. NUM_SEATS = COLS*ROWS = 8.
- SPR_W / SPR_H, 32 / 32: sprite size.
- V_COMMIT, 480: vCount line on which commits happen.
- TRANSPARENT, 12'hFFF: colour key.
- ClkPort  in  1  pixel/system clock, the only clock.
- rst  in  1  asynchronous, active-high reset.
- bright  in  1  display-area flag.
- hCount, vCount  in  10 each  beam position.
- background  in  12  colour beneath the sprites.
- upd_valid  in  1  occupancy write request.
- upd_seat  in  4  seat index.
- upd_sprite  in  2  occupant code: 0 = empty, 1..3 = character id.
- upd_ready  out  1  write accepted when valid && ready.
- rom_sprite  out  2  character select to the shared ROM.
- rom_row  out  5  ROM row address.
- rom_col  out  5  ROM column address.
- rom_data  in  12  ROM texel, one-cycle latency.
- occupancy  out  16  committed table; seat i in bits [2i+1:2i].
- frame_tick  out  1  one-cycle pulse at each frame boundary.
- rgb  out  12  registered pixel colour.

## Operation
- Seat geometry:
  - c = i % COLS, r = i / COLS.
  - Cell origin is (BASE_X + c*(SEAT_W+SEAT_SPACING), BASE_Y + r*(SEAT_H+SEAT_SPACING)).
  - Sprite origin is the cell origin + ((SEAT_W-SPR_W)/2, (SEAT_H-SPR_H)/2), integer division, = +6 with the defaults.
- Hit for seat i: hCount/vCount fall inside the sprite window [ox, ox+SPR_W) x [oy, oy+SPR_H), and the committed code for seat i ≠ 0.
- Arbitration: if more than one seat hits (only possible with a bad parameterisation), the lowest index wins.
- ROM outputs:
  - Combinational, from the winning seat: rom_sprite = its code, rom_row = vCount-oy, rom_col = hCount-ox.
  - With no hit, all three are 0.
- Two tables of NUM_SEATS x 2 bits: shadow and committed. Only the committed table drives rendering and occupancy.
- Writes: an accepted write with upd_seat < NUM_SEATS sets shadow[upd_seat] = upd_sprite. An accepted write with upd_seat ≥ NUM_SEATS is consumed and ignored, with no state change.
- Frame boundary: the cycle where vCount == V_COMMIT and hCount == 0. frame_tick is registered and is high the cycle after that cycle.
- FSM:
  - IDLE, upd_ready = 1. A valid in-range write goes to PENDING.
  - PENDING, upd_ready = 1. More writes are accepted; the frame boundary goes to COMMIT.
  - COMMIT, upd_ready = 0. Lasts exactly one cycle: committed ← shadow, then go to IDLE.
  - A frame boundary seen in IDLE does nothing except frame_tick.
- upd_ready = 0 while rst is asserted.

## Timing
- Reset (async, immediate): both tables = 0, FSM = IDLE, rgb = 0, frame_tick = 0, pipeline registers = 0.
- Pixel pipeline, with inputs presented at cycle N:
  - Stage 0 (N): hit decode and ROM address.
  - Stage 1 (N+1): rom_data valid. Registered copies of hit, bright and background are available.
  - Stage 2 (N+2): rgb ← 0 if !bright_d; else rom_data if hit_d && rom_data ≠ TRANSPARENT; else background_d.
  - Total latency is 2 cycles; rgb changes only on the clock edge.
- Update latency:
  - A write at cycle W is visible in the shadow at W+1.
  - The committed table and occupancy update on the edge that ends the COMMIT cycle, i.e. boundary cycle B + 2.
- A write accepted on the boundary cycle itself is included in that commit.
- A write presented during COMMIT stalls (upd_ready = 0) and is taken the next cycle, in IDLE.
- Reset during PENDING discards all shadow writes; no commit occurs.

## Test plan
- Reset, then bright=1, background=12'h123, no occupants → rgb = 12'h123 two cycles later. Also after reset: occupancy = 0 and upd_ready = 1.
- Write seat 1 code 2 at vCount=100 → occupancy stays 0 until vCount=480, hCount=0. Occupancy = 16'h0008 two cycles after that; frame_tick pulses once.
- After that commit, drive hCount=366, vCount=306 → rom_sprite=2, rom_row=0, rom_col=0. Then:
  - rom_data=12'hF00 → rgb = 12'hF00 at N+2.
  - rom_data=12'hFFF → rgb = background.
  - hCount=398 → rom outputs 0 and rgb = background.
- Write presented on the boundary cycle is included in the commit. A write presented on the COMMIT cycle sees upd_ready=0, is accepted the next cycle, and is committed only at the following frame.
- Write with upd_seat=9 → accepted and ignored; the FSM stays IDLE and occupancy is unchanged after the boundary. bright=0 → rgb=0 regardless of hit.
- Write seat 4 code 3, then assert rst before the boundary → after release, no commit occurs at the boundary and occupancy = 0.
